mac_result_drain: RTL and testbench

- Reader at the output end of the MAC array in top_system.
- Captures each lane's accumulator result when that lane's valid bit is high.
- Once all N_MACS lanes are captured, streams them out lane 0..N_MACS-1 over a valid/ready interface, flagging the last beat of each round.
- Sits between top_system outputs (acc_out_*, valid_out) and the downstream result consumer.

---
 rtl/mac_drain_pkg.sv | 18 +
 rtl/mac_result_drain_if.sv | 31 +++
 rtl/drain_lane_reg.sv | 39 +++
 rtl/mac_result_drain.sv | 117 +++++++++++
 tb/tb_mac_result_drain.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_drain_pkg.sv
// Shared types and defaults for the MAC result drain: FSM state encoding,
// default widths and the lane-index width helper.
package mac_drain_pkg;

  localparam int unsigned DefAccW  = 16;
  localparam int unsigned DefNMacs = 4;

  typedef logic [1:0] state_t;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StCollect = 2'd1;
  localparam state_t StDrain   = 2'd2;

  function automatic int unsigned lane_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mac_result_drain_if.sv
// Valid/ready result stream from the drain to the downstream consumer.
interface mac_result_drain_if
  import mac_drain_pkg::*;
#(
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned LANE_W = lane_w(DefNMacs)
) ();

  logic [ACC_W-1:0]  out_data;
  logic [LANE_W-1:0] out_lane;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_lane,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_lane,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/drain_lane_reg.sv
// One lane's hold register and captured flag. Clear beats capture, so a lane
// cannot be re-armed on the same edge that ends a round.
module drain_lane_reg
  import mac_drain_pkg::*;
#(
  parameter int unsigned ACC_W = DefAccW
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             cap_en_i,
  input  logic [ACC_W-1:0] data_i,
  output logic             captured_o,
  output logic [ACC_W-1:0] value_o
);

  logic             captured_q, captured_d;
  logic [ACC_W-1:0] value_q, value_d;

  always_comb begin
    captured_d = captured_q;
    value_d    = value_q;
    if (clr_i) begin
      captured_d = 1'b0;
      value_d    = '0;
    end else if (cap_en_i) begin
      captured_d = 1'b1;
      value_d    = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    captured_q <= captured_d;
    value_q    <= value_d;
  end

  assign captured_o = captured_q;
  assign value_o    = value_q;

endmodule

// File: rtl/mac_result_drain.sv
// Captures per-lane MAC results and streams them out lane 0..N_MACS-1.
// Define RESULT_RELU_EN to clamp negative results to zero at the output mux.
module mac_result_drain
  import mac_drain_pkg::*;
#(
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned N_MACS = DefNMacs,
  localparam int unsigned LANE_W = lane_w(N_MACS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [N_MACS*ACC_W-1:0] acc_in,
  input  logic [N_MACS-1:0]       valid_in,
  mac_result_drain_if.master      out_if,
  output logic                    busy,
  output logic                    overrun
);

  state_t            state_q, state_d;
  logic [LANE_W-1:0] idx_q, idx_d;
  logic              overrun_q, overrun_d;

  logic [N_MACS-1:0] captured;
  logic [N_MACS-1:0] cap_en;
  logic [N_MACS-1:0] mask_next;
  logic [ACC_W-1:0]  hold [N_MACS];
  logic [ACC_W-1:0]  sel;
  logic              out_valid;
  logic              xfer;
  logic              last_beat;
  logic              lane_clr;

  assign out_valid = (state_q == StDrain);
  assign xfer      = out_valid && out_if.out_ready;
  assign last_beat = (idx_q == LANE_W'(N_MACS - 1));
  assign cap_en    = valid_in & ~captured & {N_MACS{state_q != StDrain}};
  assign mask_next = captured | cap_en;
  assign lane_clr  = rst | clear | (xfer & last_beat);

  for (genvar i = 0; i < N_MACS; i++) begin : g_lane
    drain_lane_reg #(
      .ACC_W (ACC_W)
    ) u_lane (
      .clk_i      (clk),
      .clr_i      (lane_clr),
      .cap_en_i   (cap_en[i]),
      .data_i     (acc_in[i*ACC_W +: ACC_W]),
      .captured_o (captured[i]),
      .value_o    (hold[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    case (state_q)
      StIdle, StCollect: begin
        if (&mask_next) begin
          state_d = StDrain;
          idx_d   = '0;
        end else if (|mask_next) begin
          state_d = StCollect;
        end
      end
      StDrain: begin
        // Late valids are dropped; only the sticky flag records them.
        if (|valid_in) overrun_d = 1'b1;
        if (xfer) begin
          if (last_beat) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  assign sel = hold[idx_q];

  always_comb begin
    out_if.out_data = '0;
    if (out_valid) begin
`ifdef RESULT_RELU_EN
      out_if.out_data = sel[ACC_W-1] ? '0 : sel;
`else
      out_if.out_data = sel;
`endif
    end
  end

  assign out_if.out_valid = out_valid;
  assign out_if.out_lane  = idx_q;
  assign out_if.out_last  = out_valid && last_beat;
  assign busy             = (state_q != StIdle);
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_mac_result_drain.sv
// Directed bench for mac_result_drain with a scoreboard of expected beats.
module tb_mac_result_drain;
  import mac_drain_pkg::*;

  localparam int unsigned AccW  = 16;
  localparam int unsigned NMacs = 4;
  localparam int unsigned LaneW = 2;

  typedef struct packed {
    logic [AccW-1:0]  data;
    logic [LaneW-1:0] lane;
    logic             last;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  clear;
  logic [NMacs*AccW-1:0] acc_in;
  logic [NMacs-1:0]      valid_in;
  logic                  busy;
  logic                  overrun;

  mac_result_drain_if #(.ACC_W(AccW), .LANE_W(LaneW)) out_if ();

  mac_result_drain #(
    .ACC_W  (AccW),
    .N_MACS (NMacs)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .acc_in   (acc_in),
    .valid_in (valid_in),
    .out_if   (out_if),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  beat_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    xfers  = 0;
  logic  stall_prev = 1'b0;
  beat_t held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AccW-1:0] model_out(input logic [AccW-1:0] v);
`ifdef RESULT_RELU_EN
    return v[AccW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic beat_t mk(input logic [AccW-1:0] v, input int lane);
    beat_t b;
    b.data = model_out(v);
    b.lane = LaneW'(lane);
    b.last = (lane == NMacs - 1);
    return b;
  endfunction

  task automatic set_lanes(input logic [15:0] l0, input logic [15:0] l1,
                           input logic [15:0] l2, input logic [15:0] l3);
    acc_in = {l3, l2, l1, l0};
  endtask

  task automatic push_round(input logic [15:0] l0, input logic [15:0] l1,
                            input logic [15:0] l2, input logic [15:0] l3);
    sb.push_back(mk(l0, 0));
    sb.push_back(mk(l1, 1));
    sb.push_back(mk(l2, 2));
    sb.push_back(mk(l3, 3));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget, output int cycles);
    cycles = 0;
    while (sb.size() != 0 && cycles < budget) begin
      tick();
      cycles++;
    end
    check("drain_done", sb.size(), 0);
  endtask

  // Transfers are judged at the negedge before the edge that commits them.
  always @(negedge clk) begin
    beat_t exp_b;
    if (stall_prev) begin
      check("stall_valid", out_if.out_valid, 1);
      check("stall_data", out_if.out_data, held.data);
      check("stall_lane", out_if.out_lane, held.lane);
      check("stall_last", out_if.out_last, held.last);
    end
    stall_prev = 1'b0;
    if (!rst && !clear && out_if.out_valid) begin
      if (out_if.out_ready) begin
        xfers++;
        check("beat_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_b = sb.pop_front();
          check("beat_data", out_if.out_data, exp_b.data);
          check("beat_lane", out_if.out_lane, exp_b.lane);
          check("beat_last", out_if.out_last, exp_b.last);
        end
      end else begin
        stall_prev = 1'b1;
        held.data  = out_if.out_data;
        held.lane  = out_if.out_lane;
        held.last  = out_if.out_last;
      end
    end
  end

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation exceeded time limit");
  end

  initial begin
    int cyc;
    int x0;

    rst              = 1'b1;
    clear            = 1'b0;
    valid_in         = 4'hF;
    out_if.out_ready = 1'b0;
    set_lanes(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    tick();
    tick();
    check("rst_valid", out_if.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_if.out_data, 0);
    check("rst_lane", out_if.out_lane, 0);
    check("rst_last", out_if.out_last, 0);
    check("rst_overrun", overrun, 0);
    rst      = 1'b0;
    valid_in = '0;
    tick();
    check("rst_nocapture_busy", busy, 0);
    check("rst_nocapture_valid", out_if.out_valid, 0);

    // Simultaneous capture, full throughput.
    set_lanes(16'd5, 16'hFFFD, 16'd100, 16'h8000);
    push_round(16'd5, 16'hFFFD, 16'd100, 16'h8000);
    valid_in         = 4'hF;
    out_if.out_ready = 1'b1;
    tick();
    valid_in = '0;
    check("lat1_valid", out_if.out_valid, 1);
    check("lat1_busy", busy, 1);
    wait_drain(20, cyc);
    check("throughput_cycles", cyc, 4);
    check("sim_busy_after", busy, 0);
    check("sim_valid_after", out_if.out_valid, 0);

    // Staggered capture, lane 0 re-asserted, then backpressure.
    out_if.out_ready = 1'b0;
    set_lanes(16'd11, 16'd0, 16'd0, 16'd0);
    valid_in = 4'h1;
    tick();
    set_lanes(16'd99, 16'd22, 16'd0, 16'd0);
    valid_in = 4'h3;
    tick();
    set_lanes(16'd99, 16'd22, 16'd33, 16'd0);
    valid_in = 4'h4;
    tick();
    check("collect_busy", busy, 1);
    check("collect_not_valid", out_if.out_valid, 0);
    set_lanes(16'd99, 16'd22, 16'd33, 16'd44);
    valid_in = 4'h8;
    tick();
    valid_in = '0;
    push_round(16'd11, 16'd22, 16'd33, 16'd44);
    x0 = xfers;
    for (int k = 0; k < 40 && sb.size() != 0; k++) begin
      out_if.out_ready = (k % 4 == 0) || (k % 4 == 3);
      tick();
    end
    out_if.out_ready = 1'b0;
    check("stag_drained", sb.size(), 0);
    check("stag_xfers", xfers - x0, 4);
    check("stag_overrun", overrun, 0);

    // Overrun while draining.
    set_lanes(16'd1, 16'd2, 16'd3, 16'd4);
    valid_in = 4'hF;
    tick();
    valid_in = '0;
    push_round(16'd1, 16'd2, 16'd3, 16'd4);
    check("ovr_before", overrun, 0);
    set_lanes(16'd1, 16'd2, 16'd777, 16'd4);
    valid_in = 4'h4;
    tick();
    valid_in = '0;
    check("ovr_set", overrun, 1);
    tick();
    check("ovr_sticky", overrun, 1);
    out_if.out_ready = 1'b1;
    wait_drain(20, cyc);
    check("ovr_sticky_after_drain", overrun, 1);

    // Clear after two beats, racing a handshake.
    set_lanes(16'd10, 16'd20, 16'd30, 16'd40);
    valid_in = 4'hF;
    tick();
    valid_in = '0;
    push_round(16'd10, 16'd20, 16'd30, 16'd40);
    tick();
    tick();
    check("pre_clear_left", sb.size(), 2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_valid", out_if.out_valid, 0);
    check("clr_busy", busy, 0);
    check("clr_overrun", overrun, 0);
    check("clr_lane", out_if.out_lane, 0);
    check("clr_last", out_if.out_last, 0);
    sb.delete();

    // New round after clear; also exercises the optional clamp.
    set_lanes(16'hFFFF, 16'd7, 16'hFF38, 16'd0);
    push_round(16'hFFFF, 16'd7, 16'hFF38, 16'd0);
    valid_in = 4'hF;
    tick();
    valid_in = '0;
    check("new_round_lane0", out_if.out_lane, 0);
    check("new_round_data0", out_if.out_data, model_out(16'hFFFF));
    wait_drain(20, cyc);
    check("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
